controlador_rpn: RTL and testbench
==================================

CONTROLADOR_RPN -- requirements
Module: controlador_rpn

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 50000, meaning consecutive stable synchronized samples required to accept a button level change.
REQ-002 SHALL have port clock, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port botao_confirma, input, 1, meaning the raw asynchronous push-button, active-low.
REQ-005 SHALL have port entrada_sw, input, 8, meaning the switch bank value.
REQ-006 SHALL have ports resultado_ula (input, 8) and flags_ula (input, 4), meaning the combinational ALU result and flags.
REQ-007 SHALL have port contador, output, 2, meaning the current RPN step, fed to the step multiplexer.
REQ-008 SHALL have ports reg_a (output, 8), reg_b (output, 8), reg_sel (output, 3) and reg_carry_in (output, 1), meaning the latched ALU operands and controls.
REQ-009 SHALL have ports resultado (output, 8), flags (output, 4) and resultado_valido (output, 1), meaning the captured ALU outcome and its qualifier.

Function
REQ-010 SHALL pass botao_confirma through a 2-flop synchronizer before any use.
REQ-011 SHALL change the debounced level only after DEBOUNCE_CICLOS consecutive cycles in which the synchronized level differs from it; any agreeing sample clears the counter.
REQ-012 SHALL generate a one-cycle confirm pulse on each debounced 1->0 transition; a held button produces exactly one pulse.
REQ-013 SHALL implement the FSM PASSO_A (contador=00), PASSO_B (01), PASSO_OP (10) and PASSO_EXEC (11), with contador driven directly from the state register.
REQ-014 SHALL, on a confirm in PASSO_A, load reg_a<=entrada_sw and go to PASSO_B.
REQ-015 SHALL, on a confirm in PASSO_B, load reg_b<=entrada_sw and go to PASSO_OP.
REQ-016 SHALL, on a confirm in PASSO_OP, load reg_sel<=entrada_sw[2:0] and reg_carry_in<=entrada_sw[3], and go to PASSO_EXEC.
REQ-017 SHALL, on the first clock edge in PASSO_EXEC, capture resultado<=resultado_ula and flags<=flags_ula, and set resultado_valido to 1.
REQ-018 SHALL hold resultado, flags and resultado_valido stable for the rest of PASSO_EXEC, ignoring later ALU input changes.
REQ-019 SHALL, on a confirm in PASSO_EXEC, clear resultado_valido and leave the state as set by REQ-026/027.
REQ-020 SHALL treat a confirm coinciding with the capture cycle (REQ-017) as capture first, then apply the exit on the next confirm only.
REQ-021 SHALL leave every register unchanged in any cycle without a confirm pulse.
REQ-022 SHALL give latency from debounced press to updated contador/register of exactly 1 clock.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously force state PASSO_A and contador=00, with reg_a, reg_b, resultado=8'h00, reg_sel=3'b000, reg_carry_in=0, flags=4'h0 and resultado_valido=0.
REQ-024 SHALL, on reset, clear the synchronizer to 1, the debounced level to 1 (released) and the debounce counter to 0, so that no spurious pulse follows reset release.
REQ-025 SHALL abandon any sequence when reset is asserted mid-sequence, without partial retention.

Configuration
REQ-026 SHALL, with RPN_ENCADEAMENTO_EN defined, on a confirm in PASSO_EXEC, load reg_a<=resultado and go to PASSO_B (chained RPN).
REQ-027 SHALL, without RPN_ENCADEAMENTO_EN, on a confirm in PASSO_EXEC, go to PASSO_A, leaving reg_a unchanged.

Structure
REQ-028 SHALL take the step encodings (PASSO_A..PASSO_EXEC, 2-bit) and the widths 8/3/4 from the shared package pacote_rpn.
REQ-029 SHALL isolate the synchronizer, debouncer and edge detector in sub-module debounce_botao, parameterized by DEBOUNCE_CICLOS, with output pulso.

Verification
REQ-030 SHALL verify, with DEBOUNCE_CICLOS=4: a 3-cycle low glitch on botao_confirma -> no pulse, contador stays 00.
REQ-031 SHALL verify: presses with sw=8'h25, 8'h13, 8'h08 (sel=000, carry_in=1) and ALU model A+B+cin -> contador 00->01->10->11, resultado=8'h39, resultado_valido=1 one cycle after entering 11.
REQ-032 SHALL verify: button held low 100 cycles -> exactly one step advance.
REQ-033 SHALL verify: a press in step 11 -> without the macro, contador=00, resultado_valido=0; with RPN_ENCADEAMENTO_EN, reg_a=8'h39 and contador=01.
REQ-034 SHALL verify: reset_n pulsed low while contador=10 -> all outputs at reset values immediately, no pulse after release with the button idle high.
REQ-035 SHALL verify: ALU inputs changed while in step 11 after capture -> resultado and flags unchanged.

Source files
------------

// File: rtl/pacote_rpn.sv
// pacote_rpn: shared definitions for the RPN step controller.
//   - LARGURA_DADO / LARGURA_SEL / LARGURA_FLAGS: operand, selector and flag widths
//   - passo_t: 2-bit step encoding, driven straight onto the contador port
package pacote_rpn;

    localparam int LARGURA_DADO  = 8;
    localparam int LARGURA_SEL   = 3;
    localparam int LARGURA_FLAGS = 4;

    typedef enum logic [1:0] {
        PASSO_A    = 2'b00,
        PASSO_B    = 2'b01,
        PASSO_OP   = 2'b10,
        PASSO_EXEC = 2'b11
    } passo_t;

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: synchronizer + debouncer + press detector for an active-low button.
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   botao_n  - raw asynchronous button, active-low
//   pulso    - one-cycle pulse on each debounced 1->0 (press) transition
// The debounced level only follows the synchronized input after DEBOUNCE_CICLOS
// consecutive disagreeing samples; a single agreeing sample restarts the count.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao_n,
    output logic pulso
);

    localparam int LARGURA_CNT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS + 1) : 1;
    localparam logic [LARGURA_CNT-1:0] CNT_FIM = LARGURA_CNT'(DEBOUNCE_CICLOS - 1);

    logic                   sinc_1;
    logic                   sinc_2;
    logic                   nivel;
    logic [LARGURA_CNT-1:0] cnt;

    // Everything resets to the released (high) level so that releasing reset
    // with the button idle cannot look like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc_1 <= 1'b1;
            sinc_2 <= 1'b1;
            nivel  <= 1'b1;
            cnt    <= '0;
            pulso  <= 1'b0;
        end else begin
            sinc_1 <= botao_n;
            sinc_2 <= sinc_1;
            pulso  <= 1'b0;
            if (sinc_2 == nivel) begin
                cnt <= '0;
            end else if (cnt == CNT_FIM) begin
                nivel <= sinc_2;
                cnt   <= '0;
                // The level is flipping; it was high, so this is a press.
                pulso <= nivel;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_rpn.sv
// controlador_rpn: RPN step controller for a switch-driven ALU front panel.
// Each debounced press of botao_confirma advances A -> B -> OP -> EXEC,
// latching operands/controls from the switches; EXEC captures the ALU outcome.
// Ports:
//   clock, reset_n          - system clock / async active-low reset
//   botao_confirma          - raw active-low confirm button
//   entrada_sw              - switch bank
//   resultado_ula/flags_ula - combinational ALU result and flags
//   contador                - current step (state register)
//   reg_a, reg_b, reg_sel, reg_carry_in - latched ALU operands and controls
//   resultado, flags, resultado_valido  - captured ALU outcome and qualifier
// Configuration macro: RPN_ENCADEAMENTO_EN - when defined, a press in EXEC
// chains the result into reg_a and returns to step B; otherwise it returns
// to step A with reg_a untouched.
module controlador_rpn
    import pacote_rpn::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     botao_confirma,
    input  logic [LARGURA_DADO-1:0]  entrada_sw,
    input  logic [LARGURA_DADO-1:0]  resultado_ula,
    input  logic [LARGURA_FLAGS-1:0] flags_ula,
    output logic [1:0]               contador,
    output logic [LARGURA_DADO-1:0]  reg_a,
    output logic [LARGURA_DADO-1:0]  reg_b,
    output logic [LARGURA_SEL-1:0]   reg_sel,
    output logic                     reg_carry_in,
    output logic [LARGURA_DADO-1:0]  resultado,
    output logic [LARGURA_FLAGS-1:0] flags,
    output logic                     resultado_valido
);

    passo_t passo;
    logic   confirma;

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .botao_n (botao_confirma),
        .pulso   (confirma)
    );

    assign contador = passo;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            passo            <= PASSO_A;
            reg_a            <= '0;
            reg_b            <= '0;
            reg_sel          <= '0;
            reg_carry_in     <= 1'b0;
            resultado        <= '0;
            flags            <= '0;
            resultado_valido <= 1'b0;
        end else begin
            unique case (passo)
                PASSO_A: if (confirma) begin
                    reg_a <= entrada_sw;
                    passo <= PASSO_B;
                end
                PASSO_B: if (confirma) begin
                    reg_b <= entrada_sw;
                    passo <= PASSO_OP;
                end
                PASSO_OP: if (confirma) begin
                    reg_sel      <= entrada_sw[LARGURA_SEL-1:0];
                    reg_carry_in <= entrada_sw[LARGURA_SEL];
                    passo        <= PASSO_EXEC;
                end
                PASSO_EXEC: begin
                    // resultado_valido is always low on entry, so it doubles as
                    // the "already captured" marker. A press landing on the
                    // capture edge is swallowed; only a later press exits.
                    if (!resultado_valido) begin
                        resultado        <= resultado_ula;
                        flags            <= flags_ula;
                        resultado_valido <= 1'b1;
                    end else if (confirma) begin
                        resultado_valido <= 1'b0;
`ifdef RPN_ENCADEAMENTO_EN
                        reg_a <= resultado;
                        passo <= PASSO_B;
`else
                        passo <= PASSO_A;
`endif
                    end
                end
                default: passo <= PASSO_A;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_rpn.sv
// tb_controlador_rpn: self-checking bench for controlador_rpn (DEBOUNCE_CICLOS=4).
// A reference model of the press/step behaviour is compared against the DUT on
// every falling clock edge; directed scenarios add literal expectations.
module tb_controlador_rpn;
    import pacote_rpn::*;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao_confirma = 1'b1;
    logic [7:0] entrada_sw = 8'h00;
    logic [7:0] resultado_ula;
    logic [3:0] flags_ula;
    logic [1:0] contador;
    logic [7:0] reg_a, reg_b, resultado;
    logic [2:0] reg_sel;
    logic       reg_carry_in;
    logic [3:0] flags;
    logic       resultado_valido;

    logic        alu_override = 1'b0;
    logic [11:0] alu_val = 12'h000;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Simple ALU standing in for the external datapath: {flags, result}.
    // flags = {negative, zero, carry, overflow}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel, input logic cin);
        logic [8:0] s;
        logic       v;
        v = 1'b0;
        case (sel)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; v = (a[7] == b[7]) && (s[7] != a[7]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b};               v = (a[7] != b[7]) && (s[7] != a[7]); end
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a ^ b};
            3'd5: s = {1'b0, ~a};
            3'd6: s = {a, 1'b0};
            default: s = {a[0], 1'b0, a[7:1]};
        endcase
        return {s[7], (s[7:0] == 8'h00), s[8], v, s[7:0]};
    endfunction

    assign {flags_ula, resultado_ula} = alu_override ? alu_val
                                                     : alu_fn(reg_a, reg_b, reg_sel, reg_carry_in);

    controlador_rpn #(.DEBOUNCE_CICLOS(N)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .botao_confirma   (botao_confirma),
        .entrada_sw       (entrada_sw),
        .resultado_ula    (resultado_ula),
        .flags_ula        (flags_ula),
        .contador         (contador),
        .reg_a            (reg_a),
        .reg_b            (reg_b),
        .reg_sel          (reg_sel),
        .reg_carry_in     (reg_carry_in),
        .resultado        (resultado),
        .flags            (flags),
        .resultado_valido (resultado_valido)
    );

    // ---------------- reference model ----------------
    // Button: raw samples kept in a queue (index 0 = newest). The synchronizer
    // makes the sample seen at an edge two edges old; the debounced level flips
    // when the last N synchronized samples all disagree with it. A press is
    // acted on one edge after the level falls.
    int         m_step;
    logic [7:0] m_a, m_b, m_res;
    logic [2:0] m_sel;
    logic       m_cin, m_valid, m_deb, m_pulse, m_p;
    logic [3:0] m_flags;
    logic [11:0] m_alu;
    logic       hist[$];
    bit         m_ready = 0;
    bit         m_all;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_step = 0; m_a = 0; m_b = 0; m_res = 0; m_sel = 0; m_cin = 0;
            m_valid = 0; m_flags = 0; m_deb = 1; m_pulse = 0;
            hist = {};
            for (int i = 0; i < N + 2; i++) hist.push_back(1'b1);
            m_ready = 1;
        end else begin
            m_p = m_pulse;
            m_pulse = 0;
            m_alu = alu_override ? alu_val : alu_fn(m_a, m_b, m_sel, m_cin);
            case (m_step)
                0: if (m_p) begin m_a = entrada_sw; m_step = 1; end
                1: if (m_p) begin m_b = entrada_sw; m_step = 2; end
                2: if (m_p) begin m_sel = entrada_sw[2:0]; m_cin = entrada_sw[3]; m_step = 3; end
                default: begin
                    if (!m_valid) begin
                        {m_flags, m_res} = m_alu;
                        m_valid = 1;
                    end else if (m_p) begin
                        m_valid = 0;
`ifdef RPN_ENCADEAMENTO_EN
                        m_a = m_res;
                        m_step = 1;
`else
                        m_step = 0;
`endif
                    end
                end
            endcase
            hist.push_front(botao_confirma);
            while (hist.size() > N + 2) void'(hist.pop_back());
            m_all = 1;
            for (int i = 2; i < N + 2; i++) if (hist[i] == m_deb) m_all = 0;
            if (m_all) begin
                m_deb = ~m_deb;
                m_pulse = (m_deb == 1'b0);
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clock) begin
        if (m_ready) begin
            checks++;
            if ({contador, reg_a, reg_b, reg_sel, reg_carry_in, resultado, flags, resultado_valido} !==
                {2'(m_step), m_a, m_b, m_sel, m_cin, m_res, m_flags, m_valid}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got cnt=%0d a=%h b=%h sel=%0d cin=%0d res=%h flg=%h v=%0d expected cnt=%0d a=%h b=%h sel=%0d cin=%0d res=%h flg=%h v=%0d",
                         $time, contador, reg_a, reg_b, reg_sel, reg_carry_in, resultado, flags, resultado_valido,
                         m_step, m_a, m_b, m_sel, m_cin, m_res, m_flags, m_valid);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] sw, input int low, input int high);
        entrada_sw = sw;
        botao_confirma = 1'b0;
        repeat (low) @(negedge clock);
        botao_confirma = 1'b1;
        repeat (high) @(negedge clock);
    endtask

    bit found;

    initial begin
        // Reset
        repeat (3) @(negedge clock);
        chk("reset_state", {30'd0, contador}, 32'd0);
        chk("reset_regs", {reg_a, reg_b, resultado}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Short glitch must not advance
        press(8'hFF, 3, 10);
        chk("glitch_no_step", {30'd0, contador}, 32'd0);

        // 25 + 13 + carry
        press(8'h25, 10, 10);
        chk("step_b", {30'd0, contador}, 32'd1);
        chk("reg_a_25", {24'd0, reg_a}, 32'h25);
        press(8'h13, 10, 10);
        chk("step_op", {30'd0, contador}, 32'd2);
        chk("reg_b_13", {24'd0, reg_b}, 32'h13);

        entrada_sw = 8'h08;
        botao_confirma = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            if (contador == 2'd3) found = 1;
        end
        chk("enter_exec", {31'd0, found}, 32'd1);
        chk("valid_low_on_entry", {31'd0, resultado_valido}, 32'd0);
        @(negedge clock);
        chk("valid_after_capture", {31'd0, resultado_valido}, 32'd1);
        chk("resultado_39", {24'd0, resultado}, 32'h39);
        chk("flags_39", {28'd0, flags}, 32'h0);
        chk("sel_cin", {28'd0, reg_sel, reg_carry_in}, 32'h1);
        repeat (8) @(negedge clock);
        botao_confirma = 1'b1;
        repeat (10) @(negedge clock);
        chk("still_exec", {30'd0, contador}, 32'd3);

        // ALU inputs change after capture: outputs must hold
        alu_override = 1'b1;
        alu_val = 12'hFAA;
        repeat (5) @(negedge clock);
        chk("hold_resultado", {24'd0, resultado}, 32'h39);
        chk("hold_flags", {28'd0, flags}, 32'h0);
        alu_override = 1'b0;

        // Exit press
        press(8'h55, 10, 10);
`ifdef RPN_ENCADEAMENTO_EN
        chk("exit_chain_step", {30'd0, contador}, 32'd1);
        chk("exit_chain_reg_a", {24'd0, reg_a}, 32'h39);
`else
        chk("exit_step", {30'd0, contador}, 32'd0);
        chk("exit_reg_a_kept", {24'd0, reg_a}, 32'h25);
`endif
        chk("exit_valid", {31'd0, resultado_valido}, 32'd0);

        // Held 100 cycles: exactly one advance
        press(8'h3C, 100, 10);
`ifdef RPN_ENCADEAMENTO_EN
        chk("held_one_step", {30'd0, contador}, 32'd2);
`else
        chk("held_one_step", {30'd0, contador}, 32'd1);
        press(8'h77, 10, 10);
`endif
        chk("at_step_op", {30'd0, contador}, 32'd2);

        // Reset mid-sequence
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_cnt", {30'd0, contador}, 32'd0);
        chk("async_reset_regs", {reg_a, reg_b, resultado}, 32'd0);
        chk("async_reset_ctl", {24'd0, reg_sel, reg_carry_in, flags, resultado_valido}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("no_pulse_after_reset", {30'd0, contador}, 32'd0);

        // Randomized phase
        for (int it = 0; it < 300; it++) begin
            entrada_sw = 8'($urandom);
            alu_override = ($urandom_range(0, 7) == 0);
            alu_val = 12'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                @(posedge clock);
                #2 reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end
            botao_confirma = 1'b0;
            repeat ($urandom_range(1, 12)) @(negedge clock);
            botao_confirma = 1'b1;
            repeat ($urandom_range(1, 12)) @(negedge clock);
        end
        alu_override = 1'b0;
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
